// File: rtl/alu_lane_pkg.sv
// alu_lane_pkg: opcode encodings and opcode width shared by the ALU lane array
package alu_lane_pkg;
  localparam int OPW = 3;
  typedef logic [OPW-1:0] op_t;
  localparam op_t OP_ADD   = 3'd0;
  localparam op_t OP_SUB   = 3'd1;
  localparam op_t OP_AND   = 3'd2;
  localparam op_t OP_OR    = 3'd3;
  localparam op_t OP_XOR   = 3'd4;
  localparam op_t OP_ACC   = 3'd5;
  localparam op_t OP_SHL   = 3'd6;
  localparam op_t OP_RDACC = 3'd7;
endpackage

// File: rtl/alu_lane_array_if.sv
// alu_lane_array_if: valid/ready beat bus (in_valid/in_ready/in_a/in_b/in_op/acc_clear in, out_valid/out_ready/out_result/out_carry/out_zero/out_ovf out); slave = ALU side
interface alu_lane_array_if #(parameter int LANES = 2, parameter int WIDTH = 4) ();
  logic                              in_valid;
  logic                              in_ready;
  logic [LANES*WIDTH-1:0]            in_a;
  logic [LANES*WIDTH-1:0]            in_b;
  logic [LANES*alu_lane_pkg::OPW-1:0] in_op;
  logic                              acc_clear;
  logic                              out_valid;
  logic                              out_ready;
  logic [LANES*WIDTH-1:0]            out_result;
  logic [LANES-1:0]                  out_carry;
  logic [LANES-1:0]                  out_zero;
  logic [LANES-1:0]                  out_ovf;
  modport master (
    output in_valid, in_a, in_b, in_op, acc_clear, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, acc_clear, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_ovf
  );
endinterface

// File: rtl/alu_lane.sv
// alu_lane: one ALU lane (ports clock/resetb, i_load/i_clear/i_a/i_b/i_op in, o_result/o_carry/o_zero/o_ovf out), combinational compute plus owned accumulator
module alu_lane
  import alu_lane_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int ACC_EN = 1
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_t              i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_ovf
);
  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_base, w_x, w_y;
  logic [WIDTH:0]   w_sum, w_dif;
  logic             w_acc_op, w_acc_off, w_add_v, w_sub_v;
  assign w_acc_op  = i_op == OP_ACC;
  assign w_acc_off = (ACC_EN == 0) & (w_acc_op | (i_op == OP_RDACC));
  assign w_base    = i_clear ? '0 : r_acc;
  assign w_x       = w_acc_op ? w_base : i_a;
  assign w_y       = w_acc_op ? i_a : i_b;
  assign w_sum     = {1'b0, w_x} + {1'b0, w_y};
  assign w_dif     = {1'b0, i_a} - {1'b0, i_b};
  assign w_add_v   = (w_x[M] == w_y[M]) & (w_sum[M] != w_x[M]);
  assign w_sub_v   = (i_a[M] != i_b[M]) & (w_dif[M] != i_a[M]);
  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    o_ovf    = 1'b0;
    case (i_op)
      OP_ADD:   begin o_result = w_sum[M:0]; o_carry = w_sum[WIDTH]; o_ovf = w_add_v; end
      OP_SUB:   begin o_result = w_dif[M:0]; o_carry = w_dif[WIDTH]; o_ovf = w_sub_v; end
      OP_AND:   o_result = i_a & i_b;
      OP_OR:    o_result = i_a | i_b;
      OP_XOR:   o_result = i_a ^ i_b;
      OP_ACC:   if (ACC_EN != 0) begin o_result = w_sum[M:0]; o_carry = w_sum[WIDTH]; o_ovf = w_add_v; end
      OP_SHL:   o_result = i_a << i_b[SW-1:0];
      OP_RDACC: if (ACC_EN != 0) o_result = r_acc;
      default:  ;
    endcase
    o_zero = ~w_acc_off & (o_result == '0);
  end
  if (ACC_EN != 0) begin : g_acc
    always_ff @(posedge clock)
      if (!resetb) r_acc <= '0;
      else if (i_load & w_acc_op) r_acc <= w_sum[M:0];
      else if (i_clear) r_acc <= '0;
  end else begin : g_noacc
    assign r_acc = '0;
  end
endmodule

// File: rtl/alu_lane_array.sv
// alu_lane_array: LANES x WIDTH-bit ALU lanes behind a two-stage valid/ready pipeline (ports clock, resetb, bus = alu_lane_array_if.slave)
module alu_lane_array
  import alu_lane_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int WIDTH  = 4,
  parameter int ACC_EN = 1
) (
  input logic             clock,
  input logic             resetb,
  alu_lane_array_if.slave bus
);
  logic                   r_s1_valid, r_s2_valid;
  logic [LANES*WIDTH-1:0] r_s1_a, r_s1_b, r_result, w_result;
  logic [LANES*OPW-1:0]   r_s1_op;
  logic [LANES-1:0]       r_carry, r_zero, r_ovf, w_carry, w_zero, w_ovf;
  logic                   w_adv, w_in_ready;
  assign w_adv          = r_s1_valid & (~r_s2_valid | bus.out_ready);
  assign w_in_ready     = ~r_s1_valid | w_adv;
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_s2_valid;
  assign bus.out_result = r_result;
  assign bus.out_carry  = r_carry;
  assign bus.out_zero   = r_zero;
  assign bus.out_ovf    = r_ovf;
  always_ff @(posedge clock)
    if (!resetb) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_carry    <= '0;
      r_zero     <= '0;
      r_ovf      <= '0;
    end else begin
      if (w_in_ready) r_s1_valid <= bus.in_valid;
      if (~r_s2_valid | bus.out_ready) r_s2_valid <= r_s1_valid;
      if (w_adv) begin
        r_result <= w_result;
        r_carry  <= w_carry;
        r_zero   <= w_zero;
        r_ovf    <= w_ovf;
      end
    end
  always_ff @(posedge clock)
    if (bus.in_valid & w_in_ready) begin
      r_s1_a  <= bus.in_a;
      r_s1_b  <= bus.in_b;
      r_s1_op <= bus.in_op;
    end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    alu_lane #(.WIDTH(WIDTH), .ACC_EN(ACC_EN)) u_lane (
      .clock    (clock),
      .resetb   (resetb),
      .i_load   (w_adv),
      .i_clear  (bus.acc_clear),
      .i_a      (r_s1_a[k*WIDTH +: WIDTH]),
      .i_b      (r_s1_b[k*WIDTH +: WIDTH]),
      .i_op     (r_s1_op[k*OPW +: OPW]),
      .o_result (w_result[k*WIDTH +: WIDTH]),
      .o_carry  (w_carry[k]),
      .o_zero   (w_zero[k]),
      .o_ovf    (w_ovf[k])
    );
  end
endmodule
